// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_pkg
//  Description : Shared defaults and helpers for the programmable clock divider
//  Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int unsigned c_n_ch       = 4;
    localparam int unsigned c_cnt_w      = 32;
    localparam int unsigned c_def_period = 5;
    localparam int unsigned c_def_high   = 2;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_divider_ch.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_ch
//  Description : One divider channel with shadowed period/high-time registers
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_divider_ch
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W      = c_cnt_w,
    parameter int unsigned DEF_PERIOD = c_def_period,
    parameter int unsigned DEF_HIGH   = c_def_high
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_period,
    input  logic [CNT_W-1:0] load_high,
    input  logic             sync,
    output logic             out,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] r_p;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_ps;
    logic [CNT_W-1:0] r_hs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_out;
    logic             r_tick;

    logic w_disabled;
    logic w_wrap;
    logic w_restart;
    logic w_apply;

    assign w_disabled = (r_p == '0);
    assign w_wrap     = !w_disabled && (r_cnt == (r_p - CNT_W'(1)));
    // Every restart point is also a safe point to swap in the shadow values.
    assign w_restart  = w_wrap || sync || w_disabled;
    assign w_apply    = r_pend && w_restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p    <= CNT_W'(DEF_PERIOD);
            r_h    <= CNT_W'(DEF_HIGH);
            r_ps   <= CNT_W'(DEF_PERIOD);
            r_hs   <= CNT_W'(DEF_HIGH);
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_out  <= !w_disabled && (r_cnt < r_h);
            r_tick <= !w_disabled && (r_cnt == '0);
            r_cnt  <= w_restart ? '0 : r_cnt + CNT_W'(1);

            if (w_apply) begin
                r_p <= r_ps;
                r_h <= r_hs;
            end

            // A load coinciding with an apply refills the shadow and stays pending.
            if (load) begin
                r_ps   <= load_period;
                r_hs   <= load_high;
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign out  = r_out;
    assign tick = r_tick;
    assign pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/clk_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_prog
//  Description : N-channel runtime-programmable glitch-free clock divider
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int unsigned N_CH       = c_n_ch,
    parameter int unsigned CNT_W      = c_cnt_w,
    parameter int unsigned DEF_PERIOD = c_def_period,
    parameter int unsigned DEF_HIGH   = c_def_high
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [ch_idx_w(N_CH)-1:0]   load_ch,
    input  logic [CNT_W-1:0]            load_period,
    input  logic [CNT_W-1:0]            load_high,
    input  logic                        sync,
    output logic [N_CH-1:0]             out,
    output logic [N_CH-1:0]             tick,
    output logic [N_CH-1:0]             pend
);

    localparam int unsigned c_ch_w = ch_idx_w(N_CH);

    logic [N_CH-1:0] w_load;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range selects match no channel and are dropped here.
        assign w_load[i] = load && (load_ch == c_ch_w'(i));

        clk_divider_ch #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .load        (w_load[i]),
            .load_period (load_period),
            .load_high   (load_high),
            .sync        (sync),
            .out         (out[i]),
            .tick        (tick[i]),
            .pend        (pend[i])
        );
    end

endmodule
`default_nettype wire
